// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - IF stage: PC, instruction memory address, IF/ID latch, stall/redirect/halt
// Optional performance counters enabled by defining IFETCH_PERF_CNT_EN.
module instr_fetch_unit #(
    parameter int          pcl       = 32,
    parameter int          In        = 32,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_WORD  = 32'h0000_0000,
    parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           stall,
    input  logic           redirect_en,
    input  logic [pcl-1:0] redirect_pc,
    output logic [pcl-1:0] imem_addr,
    input  logic [In-1:0]  imem_data,
    output logic [In-1:0]  ifid_instr,
    output logic [pcl-1:0] ifid_pc4,
    output logic           ifid_valid,
    output logic [pcl-1:0] pc_out,
`ifdef IFETCH_PERF_CNT_EN
    output logic [31:0]    fetch_cnt,
    output logic [31:0]    stall_cnt,
`endif
    output logic           halted
);

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    state_t         state, state_nxt;
    logic [pcl-1:0] pc, pc_nxt, pc_plus4, redirect_word;
    logic [In-1:0]  instr_nxt;
    logic [pcl-1:0] pc4_nxt;
    logic           valid_nxt;
    logic           fetch_ev, stall_ev;

    assign pc_plus4      = pc + pcl'(4);
    assign redirect_word = redirect_pc & ~pcl'(3);
    assign imem_addr     = {2'b00, pc[pcl-1:2]};
    assign pc_out        = pc;
    assign halted        = (state == ST_HALT);

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        instr_nxt = ifid_instr;
        pc4_nxt   = ifid_pc4;
        valid_nxt = ifid_valid;
        fetch_ev  = 1'b0;
        stall_ev  = 1'b0;
        case (state)
            ST_BOOT: begin
                instr_nxt = In'(NOP_WORD);
                valid_nxt = 1'b0;
                state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (redirect_en) begin
                    pc_nxt    = redirect_word;
                    instr_nxt = In'(NOP_WORD);
                    valid_nxt = 1'b0;
                end else if (stall) begin
                    stall_ev = 1'b1;
                end else if (imem_data == In'(HALT_WORD)) begin
                    instr_nxt = In'(NOP_WORD);
                    valid_nxt = 1'b0;
                    state_nxt = ST_HALT;
                end else begin
                    instr_nxt = imem_data;
                    pc4_nxt   = pc_plus4;
                    valid_nxt = 1'b1;
                    pc_nxt    = pc_plus4;
                    fetch_ev  = 1'b1;
                end
            end
            ST_HALT: begin
                // stall is deliberately ignored here; only a redirect restarts fetching
                instr_nxt = In'(NOP_WORD);
                valid_nxt = 1'b0;
                if (redirect_en) begin
                    pc_nxt    = redirect_word;
                    state_nxt = ST_RUN;
                end
            end
            default: begin
                state_nxt = ST_BOOT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_BOOT;
            pc         <= pcl'(RESET_PC);
            ifid_instr <= In'(NOP_WORD);
            ifid_pc4   <= '0;
            ifid_valid <= 1'b0;
        end else begin
            state      <= state_nxt;
            pc         <= pc_nxt;
            ifid_instr <= instr_nxt;
            ifid_pc4   <= pc4_nxt;
            ifid_valid <= valid_nxt;
        end
    end

`ifdef IFETCH_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            if (fetch_ev && fetch_cnt != 32'hFFFF_FFFF) fetch_cnt <= fetch_cnt + 32'd1;
            if (stall_ev && stall_cnt != 32'hFFFF_FFFF) stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - directed self-checking bench for instr_fetch_unit
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        redirect_en;
    logic [31:0] redirect_pc;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_pc4;
    logic        ifid_valid;
    logic [31:0] pc_out;
    logic        halted;
`ifdef IFETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt;
    logic [31:0] stall_cnt;
`endif

    logic [31:0] mem [0:63];
    int passed = 0;
    int total  = 0;

    assign imem_data = mem[imem_addr[5:0]];

    always #5 clk = ~clk;

    instr_fetch_unit dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .stall      (stall),
        .redirect_en(redirect_en),
        .redirect_pc(redirect_pc),
        .imem_addr  (imem_addr),
        .imem_data  (imem_data),
        .ifid_instr (ifid_instr),
        .ifid_pc4   (ifid_pc4),
        .ifid_valid (ifid_valid),
        .pc_out     (pc_out),
`ifdef IFETCH_PERF_CNT_EN
        .fetch_cnt  (fetch_cnt),
        .stall_cnt  (stall_cnt),
`endif
        .halted     (halted)
    );

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        stall = 1'b0; redirect_en = 1'b0; redirect_pc = '0;
        do_reset();
        total++; if (pc_out !== 32'h0) $display("FAIL reset_pc: got %h want %h", pc_out, 32'h0); else passed++;
        total++; if ({ifid_valid, halted} !== 2'b00) $display("FAIL reset_flags: got %b want 00", {ifid_valid, halted}); else passed++;
        total++; if (ifid_instr !== 32'h0) $display("FAIL reset_instr: got %h want 0", ifid_instr); else passed++;
        total++; if (ifid_pc4 !== 32'h0) $display("FAIL reset_pc4: got %h want 0", ifid_pc4); else passed++;
`ifdef IFETCH_PERF_CNT_EN
        total++; if ({fetch_cnt, stall_cnt} !== 64'h0) $display("FAIL reset_cnt: got %h/%h want 0/0", fetch_cnt, stall_cnt); else passed++;
`endif
    endtask

    task automatic test_sequential();
        do_reset();
        step();
        total++; if ({ifid_valid, pc_out} !== {1'b0, 32'h0}) $display("FAIL boot_bubble: got v=%b pc=%h want v=0 pc=0", ifid_valid, pc_out); else passed++;
        for (int i = 0; i < 4; i++) begin
            step();
            total++;
            if (ifid_instr !== 32'h1000_0000 + i || ifid_pc4 !== 32'(4 * (i + 1)) || ifid_valid !== 1'b1)
                $display("FAIL seq_fetch%0d: got %h/%h/%b want %h/%h/1", i, ifid_instr, ifid_pc4, ifid_valid,
                         32'h1000_0000 + i, 32'(4 * (i + 1)));
            else passed++;
        end
    endtask

    task automatic test_stall();
        do_reset();
        step(); step(); step();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            total++;
            if (pc_out !== 32'h8 || ifid_instr !== 32'h1000_0001 || ifid_pc4 !== 32'h8 || ifid_valid !== 1'b1)
                $display("FAIL stall_hold%0d: got pc=%h %h/%h/%b want pc=8 10000001/8/1", i, pc_out, ifid_instr, ifid_pc4, ifid_valid);
            else passed++;
        end
`ifdef IFETCH_PERF_CNT_EN
        total++; if ({fetch_cnt, stall_cnt} !== {32'd2, 32'd3}) $display("FAIL stall_cnt: got %0d/%0d want 2/3", fetch_cnt, stall_cnt); else passed++;
`endif
        stall = 1'b0;
        step();
        total++;
        if (ifid_instr !== 32'h1000_0002 || ifid_pc4 !== 32'hC || pc_out !== 32'hC)
            $display("FAIL stall_release: got %h/%h pc=%h want 10000002/c pc=c", ifid_instr, ifid_pc4, pc_out);
        else passed++;
    endtask

    task automatic test_redirect();
        redirect_en = 1'b1; redirect_pc = 32'h22; stall = 1'b1;
        step();
        redirect_en = 1'b0; stall = 1'b0;
        total++; if ({pc_out, ifid_valid} !== {32'h20, 1'b0}) $display("FAIL redirect_pc: got pc=%h v=%b want pc=20 v=0", pc_out, ifid_valid); else passed++;
        step();
        total++;
        if (ifid_instr !== 32'h1000_0008 || ifid_pc4 !== 32'h24 || ifid_valid !== 1'b1)
            $display("FAIL redirect_fetch: got %h/%h/%b want 10000008/24/1", ifid_instr, ifid_pc4, ifid_valid);
        else passed++;
`ifdef IFETCH_PERF_CNT_EN
        total++; if ({fetch_cnt, stall_cnt} !== {32'd4, 32'd3}) $display("FAIL redirect_cnt: got %0d/%0d want 4/3", fetch_cnt, stall_cnt); else passed++;
`endif
    endtask

    task automatic test_halt();
        mem[5] = 32'hFFFF_FFFF;
        do_reset();
        for (int i = 0; i < 6; i++) step();
        total++; if ({halted, pc_out} !== {1'b0, 32'h14}) $display("FAIL pre_halt: got h=%b pc=%h want h=0 pc=14", halted, pc_out); else passed++;
        step();
        total++; if ({halted, ifid_valid, pc_out} !== {2'b10, 32'h14}) $display("FAIL halt_enter: got h=%b v=%b pc=%h want h=1 v=0 pc=14", halted, ifid_valid, pc_out); else passed++;
        for (int i = 0; i < 10; i++) begin
            stall = i[0];
            step();
            total++;
            if (halted !== 1'b1 || pc_out !== 32'h14 || ifid_valid !== 1'b0 || ifid_instr !== 32'h0)
                $display("FAIL halt_frozen%0d: got h=%b pc=%h v=%b i=%h want h=1 pc=14 v=0 i=0", i, halted, pc_out, ifid_valid, ifid_instr);
            else passed++;
        end
        stall = 1'b0; redirect_en = 1'b1; redirect_pc = 32'h0;
        step();
        redirect_en = 1'b0;
        mem[5] = 32'h1000_0005;
        total++; if ({halted, ifid_valid, pc_out} !== {2'b00, 32'h0}) $display("FAIL halt_exit: got h=%b v=%b pc=%h want 0/0/0", halted, ifid_valid, pc_out); else passed++;
        step();
        total++;
        if (ifid_instr !== 32'h1000_0000 || ifid_pc4 !== 32'h4 || ifid_valid !== 1'b1)
            $display("FAIL halt_resume: got %h/%h/%b want 10000000/4/1", ifid_instr, ifid_pc4, ifid_valid);
        else passed++;
    endtask

    task automatic test_wrap();
        redirect_en = 1'b1; redirect_pc = 32'hFFFF_FFFF;
        step();
        redirect_en = 1'b0;
        total++; if (pc_out !== 32'hFFFF_FFFC) $display("FAIL wrap_redirect: got %h want fffffffc", pc_out); else passed++;
        step();
        total++;
        if (pc_out !== 32'h0 || ifid_pc4 !== 32'h0 || ifid_instr !== 32'h1000_003F || ifid_valid !== 1'b1)
            $display("FAIL wrap_pc: got pc=%h %h/%h/%b want pc=0 1000003f/0/1", pc_out, ifid_instr, ifid_pc4, ifid_valid);
        else passed++;
    endtask

    task automatic test_reset_mid();
        redirect_en = 1'b1; redirect_pc = 32'h40;
        step();
        total++; if (pc_out !== 32'h40) $display("FAIL mid_setup: got %h want 40", pc_out); else passed++;
        redirect_pc = 32'h80; stall = 1'b1;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1; redirect_en = 1'b0; stall = 1'b0;
        total++; if ({pc_out, ifid_valid, halted} !== {32'h0, 2'b00}) $display("FAIL mid_reset: got pc=%h v=%b h=%b want 0/0/0", pc_out, ifid_valid, halted); else passed++;
`ifdef IFETCH_PERF_CNT_EN
        total++; if ({fetch_cnt, stall_cnt} !== 64'h0) $display("FAIL mid_reset_cnt: got %0d/%0d want 0/0", fetch_cnt, stall_cnt); else passed++;
`endif
        step();
        total++; if ({pc_out, ifid_valid} !== {32'h0, 1'b0}) $display("FAIL mid_boot: got pc=%h v=%b want 0/0", pc_out, ifid_valid); else passed++;
        step();
        total++; if ({ifid_instr, ifid_valid} !== {32'h1000_0000, 1'b1}) $display("FAIL mid_first: got %h/%b want 10000000/1", ifid_instr, ifid_valid); else passed++;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'h1000_0000 + 32'(i);
        rst_n = 1'b1; stall = 1'b0; redirect_en = 1'b0; redirect_pc = '0;
        @(negedge clk);
        test_reset();
        test_sequential();
        test_stall();
        test_redirect();
        test_halt();
        test_wrap();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
